piso_register: RTL and testbench

//  Parallel-in serial-out buffer with valid/ready handshakes on both sides.

---
 rtl/hash_pkg.sv | 7 +
 rtl/piso_register.sv | 53 +++++
 tb/tb_piso_register.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hash_pkg.sv
// hash_pkg: shared types and helpers for the hashtable read path.
package hash_pkg;
  typedef enum logic {IDLE, SHIFT} piso_state_t;
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/piso_register.sv
// piso_register: parallel bucket word in, one slot per accepted beat out, lowest slot first.
module piso_register
  import hash_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int WORDS = 4,
  localparam int IDX_W = idx_width(WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_valid_i,
  output logic                        load_ready_o,
  input  logic [WORDS*DATA_WIDTH-1:0] data_i,
  output logic                        data_valid_o,
  input  logic                        data_ready_i,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic [IDX_W-1:0]            index_o,
  output logic                        last_o
);
  localparam int NX = (WORDS > 1) ? 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  piso_state_t state, state_next;
  logic [DATA_WIDTH-1:0] store [WORDS-1:0];
  logic load_fire, beat_fire;
  assign data_valid_o = state == SHIFT;
  assign last_o = data_valid_o && index_o == LAST_IDX;
  // Accepting a new word while the last beat leaves keeps buckets bubble-free.
  assign load_ready_o = !data_valid_o || (last_o && data_ready_i);
  always_comb begin
    load_fire = load_valid_i && load_ready_o;
    beat_fire = data_valid_o && data_ready_i;
    state_next = load_fire ? SHIFT : (beat_fire && last_o) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      data_o <= '0;
      index_o <= '0;
      for (int k = 0; k < WORDS; k++) store[k] <= '0;
    end else begin
      state <= state_next;
      if (load_fire) begin
        for (int k = 0; k < WORDS; k++) store[k] <= data_i[k*DATA_WIDTH +: DATA_WIDTH];
        data_o <= data_i[DATA_WIDTH-1:0];
        index_o <= '0;
      end else if (beat_fire && !last_o) begin
        for (int k = 0; k < WORDS - 1; k++) store[k] <= store[k+1];
        data_o <= store[NX];
        index_o <= index_o + IDX_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_piso_register.sv
// tb_piso_register: scoreboard bench for piso_register (8x4 main instance, 10x1 corner instance).
module tb_piso_register;
  localparam int DW = 8;
  localparam int W = 4;
  logic clk = 0;
  logic reset = 0;
  logic load_valid_i = 0;
  logic data_ready_i = 0;
  logic [W*DW-1:0] data_i = '0;
  logic load_ready_o, data_valid_o, last_o;
  logic [DW-1:0] data_o;
  logic [1:0] index_o;
  logic lv2 = 0, dr2 = 0, lr2, dv2, last2;
  logic [9:0] d2i = '0, d2o;
  logic [0:0] idx2;
  typedef struct {logic [DW-1:0] d; int i; logic l;} beat_t;
  beat_t q[$];
  int log_d[$], log_c[$], lr_d[$];
  int cyc = 0, passed = 0, total = 0;
  bit done = 0;

  piso_register #(.DATA_WIDTH(DW), .WORDS(W)) dut (
    .clk(clk), .reset(reset), .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .data_i(data_i), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .data_o(data_o), .index_o(index_o), .last_o(last_o));

  piso_register #(.DATA_WIDTH(10), .WORDS(1)) dut1 (
    .clk(clk), .reset(reset), .load_valid_i(lv2), .load_ready_o(lr2),
    .data_i(d2i), .data_valid_o(dv2), .data_ready_i(dr2),
    .data_o(d2o), .index_o(idx2), .last_o(last2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Model: each accepted word becomes WORDS pending beats; a beat is owed whenever any are pending.
  always @(negedge clk) if (reset) begin
    beat_t e;
    chk("valid", data_valid_o, q.size() != 0);
    chk("load_ready", load_ready_o, q.size() == 0 || (q.size() == 1 && data_ready_i));
    if (data_valid_o && load_ready_o) lr_d.push_back(int'(data_o));
    if (data_valid_o && data_ready_i && q.size() != 0) begin
      e = q.pop_front();
      chk("data", data_o, e.d);
      chk("index", index_o, e.i);
      chk("last", last_o, e.l);
      log_d.push_back(int'(data_o));
      log_c.push_back(cyc);
    end
    if (load_valid_i && load_ready_o)
      for (int k = 0; k < W; k++) q.push_back('{data_i[k*DW +: DW], k, k == W - 1});
  end

  task automatic load(input logic [31:0] w);
    int n = 0;
    load_valid_i = 1;
    data_i = w;
    @(negedge clk);
    while (!load_ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) timeout("load_wait");
    @(posedge clk);
    #1 load_valid_i = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || data_valid_o) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) timeout("drain");
    #1;
  endtask

  task automatic check_log(input string name, input int n, input bit consec);
    chk({name, "_count"}, log_d.size(), n);
    for (int i = 0; i < n && i < log_d.size(); i++) begin
      chk({name, "_slot"}, log_d[i], 32'h11 * (i + 1));
      if (consec) chk({name, "_cycle"}, log_c[i], log_c[0] + i);
    end
  endtask

  initial begin
    #2;
    chk("rst_valid", data_valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_index", index_o, 0);
    chk("rst_load_ready", load_ready_o, 1);
    #10 reset = 1;
    @(posedge clk);
    #1 data_ready_i = 1;
    // single word
    log_d.delete(); log_c.delete();
    load(32'h44332211);
    drain();
    check_log("single", 4, 1);
    chk("single_idle_ready", load_ready_o, 1);
    // backpressure on the second beat
    log_d.delete(); log_c.delete();
    load(32'h44332211);
    @(posedge clk);
    #1 chk("bp_data", data_o, 8'h22);
    data_ready_i = 0;
    repeat (3) begin
      @(posedge clk);
      #1 chk("bp_hold_data", data_o, 8'h22);
      chk("bp_hold_index", index_o, 1);
    end
    data_ready_i = 1;
    drain();
    check_log("bp", 4, 0);
    // back-to-back words
    log_d.delete(); log_c.delete(); lr_d.delete();
    load(32'h44332211);
    load(32'h88776655);
    drain();
    check_log("b2b", 8, 1);
    chk("b2b_lr_count", lr_d.size(), 2);
    if (lr_d.size() == 2) begin
      chk("b2b_lr_first", lr_d[0], 8'h44);
      chk("b2b_lr_second", lr_d[1], 8'h88);
    end
    // single-slot instance
    lv2 = 1; d2i = 10'h3FF; dr2 = 1;
    @(posedge clk);
    #1 chk("w1_data0", d2o, 10'h3FF);
    chk("w1_valid0", dv2, 1); chk("w1_last0", last2, 1); chk("w1_index0", idx2, 0); chk("w1_ready0", lr2, 1);
    d2i = 10'h001;
    @(posedge clk);
    #1 chk("w1_data1", d2o, 10'h001);
    chk("w1_valid1", dv2, 1); chk("w1_last1", last2, 1); chk("w1_index1", idx2, 0);
    lv2 = 0;
    @(posedge clk);
    #1 chk("w1_idle", dv2, 0);
    chk("w1_idle_last", last2, 0);
    // reset in the middle of a word
    load(32'h44332211);
    begin
      int n = 0;
      while (!(data_valid_o && data_o == 8'h33) && n < 20) begin
        @(posedge clk);
        #1 n++;
      end
      if (n >= 20) timeout("reset_wait");
    end
    #2 reset = 0;
    #1 chk("mid_rst_valid", data_valid_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_index", index_o, 0);
    chk("mid_rst_last", last_o, 0);
    chk("mid_rst_ready", load_ready_o, 1);
    q.delete();
    @(posedge clk);
    #2 reset = 1;
    @(posedge clk);
    #1 chk("post_rst_valid", data_valid_o, 0);
    log_d.delete(); log_c.delete();
    load(32'h44332211);
    drain();
    check_log("post_rst", 4, 1);
    // random traffic
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          load($urandom);
        end
        drain();
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 data_ready_i = $urandom_range(0, 3) != 0;
        end
      end
    join
    chk("rand_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
